i2c_cond_gen: RTL and testbench

Master-side I2C bus-condition generator. It drives SDA/SCL to produce START, repeated START (RSTART) and STOP conditions with programmable timing, counted in sample_clk cycles. It is the transmit counterpart of the slave start/stop detector, and the detector must recognise every condition this block produces. It sits below the future master byte engine, which issues one command at a time over a valid/ready handshake.

---
 rtl/i2c_pkg.sv | 52 +++++
 rtl/i2c_phase_timer.sv | 32 +++
 rtl/i2c_cond_gen.sv | 183 ++++++++++++++++++
 tb/tb_i2c_cond_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command codes, condition-generator states and
// the state-to-line decode used by the condition generator.
package i2c_pkg;

    localparam logic [1:0] CMD_NOP    = 2'd0;
    localparam logic [1:0] CMD_START  = 2'd1;
    localparam logic [1:0] CMD_RSTART = 2'd2;
    localparam logic [1:0] CMD_STOP   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SU,
        ST_HD,
        ST_R_LOW,
        ST_R_WAIT,
        ST_R_SU,
        ST_R_HD,
        ST_P_LOW,
        ST_P_WAIT,
        ST_P_SU,
        ST_P_BUF
    } cg_state_e;

    typedef struct packed {
        logic scl;
        logic sda;
    } line_drv_t;

    // Line drive for each state. 1 = release, 0 = pull low.
    // In IDLE the bus is held low while we own it, released otherwise.
    function automatic line_drv_t state_lines(cg_state_e st, logic busy);
        line_drv_t l;
        l.scl = 1'b1;
        l.sda = 1'b1;
        case (st)
            ST_IDLE:   begin l.scl = ~busy; l.sda = ~busy; end
            ST_SU:     begin l.scl = 1'b1;  l.sda = 1'b1;  end
            ST_HD:     begin l.scl = 1'b1;  l.sda = 1'b0;  end
            ST_R_LOW:  begin l.scl = 1'b0;  l.sda = 1'b1;  end
            ST_R_WAIT: begin l.scl = 1'b1;  l.sda = 1'b1;  end
            ST_R_SU:   begin l.scl = 1'b1;  l.sda = 1'b1;  end
            ST_R_HD:   begin l.scl = 1'b1;  l.sda = 1'b0;  end
            ST_P_LOW:  begin l.scl = 1'b0;  l.sda = 1'b0;  end
            ST_P_WAIT: begin l.scl = 1'b1;  l.sda = 1'b0;  end
            ST_P_SU:   begin l.scl = 1'b1;  l.sda = 1'b0;  end
            ST_P_BUF:  begin l.scl = 1'b1;  l.sda = 1'b1;  end
            default:   begin l.scl = 1'b1;  l.sda = 1'b1;  end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Load/decrement down-counter with a zero flag. Loading N gives a phase
// of N+1 cycles when the owner exits on the cycle after zero is reached.
module i2c_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_cond_gen.sv
// Master-side I2C START / repeated START / STOP generator. One command at
// a time over valid/ready; all line drives decode from registered state.
module i2c_cond_gen
    import i2c_pkg::*;
#(
    parameter int T_SU  = 4,
    parameter int T_HD  = 4,
    parameter int T_LOW = 5,
    parameter int T_BUF = 6,
    parameter int CNT_W = 8
) (
    input  logic       sample_clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       bus_busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_HD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] LD_LOW = CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] LD_BUF = CNT_W'(T_BUF - 1);

    cg_state_e        state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    line_drv_t        lines;

    i2c_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (sample_clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state: command decode in IDLE, timed phases exit on the cycle
    // after the timer hits zero, wait phases exit once SCL reads high.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_START: begin
                            if (busy_q) err_d = 1'b1;
                            else begin
                                state_d  = ST_SU;
                                tmr_load = 1'b1;
                                tmr_val  = LD_SU;
                            end
                        end
                        CMD_RSTART: begin
                            if (!busy_q) err_d = 1'b1;
                            else begin
                                state_d  = ST_R_LOW;
                                tmr_load = 1'b1;
                                tmr_val  = LD_LOW;
                            end
                        end
                        CMD_STOP: begin
                            if (!busy_q) err_d = 1'b1;
                            else begin
                                state_d  = ST_P_LOW;
                                tmr_load = 1'b1;
                                tmr_val  = LD_LOW;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SU: begin
                if (tmr_zero) begin
                    // SDA held low by someone else: bus not free, abort.
                    if (!sda_i) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_HD;
                        tmr_load = 1'b1;
                        tmr_val  = LD_HD;
                    end
                end
            end
            ST_HD: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            ST_R_LOW: if (tmr_zero) state_d = ST_R_WAIT;
            ST_R_WAIT: begin
                if (scl_i) begin
                    state_d  = ST_R_SU;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SU;
                end
            end
            ST_R_SU: begin
                if (tmr_zero) begin
                    state_d  = ST_R_HD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HD;
                end
            end
            ST_R_HD: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_P_LOW: if (tmr_zero) state_d = ST_P_WAIT;
            ST_P_WAIT: begin
                if (scl_i) begin
                    state_d  = ST_P_SU;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SU;
                end
            end
            ST_P_SU: begin
                if (tmr_zero) begin
                    state_d  = ST_P_BUF;
                    tmr_load = 1'b1;
                    tmr_val  = LD_BUF;
                end
            end
            ST_P_BUF: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, bus ownership and status pulse registers.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Line drives are a pure decode of registered state.
    always_comb begin
        lines = state_lines(state_q, busy_q);
    end

    assign scl_o     = lines.scl;
    assign sda_o     = lines.sda;
    assign cmd_ready = (state_q == ST_IDLE);
    assign bus_busy  = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_i2c_cond_gen.sv
// Self-checking bench for i2c_cond_gen: table of commands, random commands,
// each checked cycle by cycle against a phase-list model of the bus.
module tb_i2c_cond_gen;
    import i2c_pkg::*;

    localparam int T_SU  = 4;
    localparam int T_HD  = 4;
    localparam int T_LOW = 5;
    localparam int T_BUF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready, scl_i, sda_i, scl_o, sda_o, bus_busy, done, err;
    logic       hold_low, sda_low;

    always #5 clk = ~clk;

    // Open-drain loopback; bench can stretch SCL or hold SDA low.
    assign scl_i = scl_o & ~hold_low;
    assign sda_i = sda_o & ~sda_low;

    i2c_cond_gen #(.T_SU(T_SU), .T_HD(T_HD), .T_LOW(T_LOW), .T_BUF(T_BUF), .CNT_W(8)) dut (
        .sample_clk (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .bus_busy   (bus_busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic scl;
        logic sda;
        logic busy;
        logic done;
        logic err;
        logic rdy;
    } obs_t;

    typedef struct {
        logic [1:0] c;
        int         s;
        bit         blk;
        bit         busy;
        int         nd;
        int         ne;
    } vec_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_busy  = 1'b0;
    int   exp_starts, exp_stops;

    function automatic obs_t mk(bit scl, bit sda, bit busy, bit dn, bit er, bit rdy);
        obs_t o;
        o = {scl, sda, busy, dn, er, rdy};
        return o;
    endfunction

    function automatic void add(int n, obs_t o);
        for (int k = 0; k < n; k++) exp_q.push_back(o);
    endfunction

    // Expected per-cycle observation list, starting with the cycle after
    // the accepting edge, built as a sequence of phase lengths.
    function automatic void build(logic [1:0] c, int s, bit blk);
        bit b;
        b = m_busy;
        exp_q.delete();
        exp_starts = 0;
        exp_stops  = 0;
        if (c == CMD_NOP) begin
            add(1, mk(!b, !b, b, 0, 0, 1));
        end else if ((c == CMD_START && b) || (c != CMD_START && !b)) begin
            add(1, mk(!b, !b, b, 0, 1, 1));
            add(1, mk(!b, !b, b, 0, 0, 1));
        end else if (c == CMD_START) begin
            add(T_SU, mk(1, 1, 0, 0, 0, 0));
            if (blk) begin
                add(1, mk(1, 1, 0, 0, 1, 1));
                add(1, mk(1, 1, 0, 0, 0, 1));
            end else begin
                add(T_HD, mk(1, 0, 0, 0, 0, 0));
                add(1, mk(0, 0, 1, 1, 0, 1));
                add(1, mk(0, 0, 1, 0, 0, 1));
                exp_starts = 1;
                m_busy = 1'b1;
            end
        end else if (c == CMD_RSTART) begin
            add(T_LOW, mk(0, 1, 1, 0, 0, 0));
            add(s + 1, mk(1, 1, 1, 0, 0, 0));
            add(T_SU,  mk(1, 1, 1, 0, 0, 0));
            add(T_HD,  mk(1, 0, 1, 0, 0, 0));
            add(1, mk(0, 0, 1, 1, 0, 1));
            add(1, mk(0, 0, 1, 0, 0, 1));
            exp_starts = 1;
        end else begin
            add(T_LOW, mk(0, 0, 1, 0, 0, 0));
            add(s + 1, mk(1, 0, 1, 0, 0, 0));
            add(T_SU,  mk(1, 0, 1, 0, 0, 0));
            add(T_BUF, mk(1, 1, 1, 0, 0, 0));
            add(1, mk(1, 1, 0, 1, 0, 1));
            add(1, mk(1, 1, 0, 0, 0, 1));
            exp_stops = 1;
            m_busy = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Issue one command and compare every cycle until it has settled.
    task automatic run_cmd(input logic [1:0] c, input int s, input bit blk,
                           output int nd, output int ne);
        logic ps, pd;
        int   starts, stops;
        obs_t got;
        bit   stretchy;
        build(c, s, blk);
        stretchy = (c == CMD_RSTART || c == CMD_STOP);
        @(negedge clk);
        cmd = c; cmd_valid = 1'b1; sda_low = blk;
        ps = scl_o; pd = sda_o;
        starts = 0; stops = 0; nd = 0; ne = 0;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            cmd_valid = 1'b0; cmd = CMD_NOP;
            hold_low = stretchy && (i < T_LOW + s);
            @(negedge clk);
            got = {scl_o, sda_o, bus_busy, done, err, cmd_ready};
            chk($sformatf("cyc%0d cmd%0d {scl,sda,busy,done,err,rdy}", i, c), 32'(got), 32'(exp_q[i]));
            if (ps && scl_o && pd && !sda_o) starts++;
            if (ps && scl_o && !pd && sda_o) stops++;
            ps = scl_o; pd = sda_o;
            nd += int'(done);
            ne += int'(err);
            if (i != exp_q.size() - 1) @(posedge clk);
        end
        hold_low = 1'b0;
        sda_low  = 1'b0;
        chk("detector starts", 32'(starts), 32'(exp_starts));
        chk("detector stops", 32'(stops), 32'(exp_stops));
    endtask

    vec_t tbl[12];

    initial begin
        int nd, ne;
        logic [1:0] c;
        int s;
        bit blk;

        tbl[0]  = '{CMD_NOP,    0,  0, 0, 0, 0};
        tbl[1]  = '{CMD_STOP,   0,  0, 0, 0, 1};
        tbl[2]  = '{CMD_RSTART, 0,  0, 0, 0, 1};
        tbl[3]  = '{CMD_START,  0,  1, 0, 0, 1};
        tbl[4]  = '{CMD_START,  0,  0, 1, 1, 0};
        tbl[5]  = '{CMD_START,  0,  0, 1, 0, 1};
        tbl[6]  = '{CMD_RSTART, 0,  0, 1, 1, 0};
        tbl[7]  = '{CMD_RSTART, 3,  0, 1, 1, 0};
        tbl[8]  = '{CMD_NOP,    0,  0, 1, 0, 0};
        tbl[9]  = '{CMD_STOP,   10, 0, 0, 1, 0};
        tbl[10] = '{CMD_START,  0,  0, 1, 1, 0};
        tbl[11] = '{CMD_STOP,   0,  0, 0, 1, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd = CMD_NOP; hold_low = 1'b0; sda_low = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", 32'({scl_o, sda_o, bus_busy, done, err, cmd_ready}), 32'(mk(1, 1, 0, 0, 0, 1)));
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset idle", 32'({scl_o, sda_o, bus_busy, done, err, cmd_ready}), 32'(mk(1, 1, 0, 0, 0, 1)));

        for (int v = 0; v < 12; v++) begin
            run_cmd(tbl[v].c, tbl[v].s, tbl[v].blk, nd, ne);
            chk($sformatf("vec%0d done count", v), 32'(nd), 32'(tbl[v].nd));
            chk($sformatf("vec%0d err count", v), 32'(ne), 32'(tbl[v].ne));
            chk($sformatf("vec%0d bus_busy", v), 32'(bus_busy), 32'(tbl[v].busy));
        end

        for (int r = 0; r < 40; r++) begin
            c   = 2'($urandom_range(0, 3));
            s   = int'($urandom_range(0, 6));
            blk = (c == CMD_START) && ($urandom_range(0, 5) == 0);
            run_cmd(c, s, blk, nd, ne);
            chk($sformatf("rnd%0d busy vs model", r), 32'(bus_busy), 32'(m_busy));
        end

        // Reset in the middle of a STOP's setup phase.
        if (!m_busy) run_cmd(CMD_START, 0, 0, nd, ne);
        @(negedge clk);
        cmd = CMD_STOP; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd = CMD_NOP;
        repeat (T_LOW + 1 + 1) @(negedge clk);
        chk("in P_SU lines", 32'({scl_o, sda_o, bus_busy, cmd_ready}), 32'(4'b1010));
        rst = 1'b1;
        #1;
        chk("async reset mid P_SU", 32'({scl_o, sda_o, bus_busy, done, err, cmd_ready}), 32'(mk(1, 1, 0, 0, 0, 1)));
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        @(negedge clk);
        chk("after reset release", 32'({scl_o, sda_o, bus_busy, done, err, cmd_ready}), 32'(mk(1, 1, 0, 0, 0, 1)));
        run_cmd(CMD_START, 0, 0, nd, ne);
        chk("start after reset done", 32'(nd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
